// File: rtl/dmem_mmio.sv
// Data-side responder for the single-cycle CPU: byte-lane RAM plus an MMIO block
// holding a cycle counter, an LED register and a buffered TX byte stream.
module dmem_mmio #(
  parameter int MEM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  we,
  output logic [31:0] drdata,
  output logic [31:0] led,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0] REG_CYCLE  = 4'd0;
  localparam logic [3:0] REG_LED    = 4'd1;
  localparam logic [3:0] REG_TXDATA = 4'd2;
  localparam logic [3:0] REG_STATUS = 4'd3;

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   cycle_cnt;
  logic [31:0]   led_reg;
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr;
  logic [FW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overrun;

  logic          is_mmio;
  logic [3:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          wr_any;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic [31:0]   count_ext;
  logic [3:0]    occupancy;
  logic [31:0]   status_word;
  logic          unused_addr_bits;

  assign is_mmio  = (daddr[31:16] == 16'hFFFF);
  assign reg_sel  = daddr[5:2];
  assign ram_idx  = daddr[AW+1:2];
  assign wr_any   = |we;
  // Only parts of the address are decoded; fold the rest so every bit is consumed.
  assign unused_addr_bits = ^daddr;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = tx_valid && tx_ready;
  assign push_req   = is_mmio && (reg_sel == REG_TXDATA) && we[0];
  assign push_ok    = push_req && (!fifo_full || pop);

  assign count_ext   = 32'(count);
  assign occupancy   = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign status_word = {24'd0, occupancy, 1'b0, overrun, fifo_full, fifo_empty};

  assign led      = led_reg;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo[rd_ptr];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset && !is_mmio && we[i]) mem[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (is_mmio && (reg_sel == REG_CYCLE) && wr_any) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) cycle_cnt[8*i +: 8] <= dwdata[8*i +: 8];
      end
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_reg <= '0;
    end else if (is_mmio && (reg_sel == REG_LED)) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) led_reg[8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) fifo[wr_ptr] <= dwdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push and a clear cannot coincide: they target different offsets.
      if (push_req && fifo_full && !pop) begin
        overrun <= 1'b1;
      end else if (is_mmio && (reg_sel == REG_STATUS) && we[0] && dwdata[2]) begin
        overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    drdata = '0;
    if (is_mmio) begin
      case (reg_sel)
        REG_CYCLE:  drdata = cycle_cnt;
        REG_LED:    drdata = led_reg;
        REG_STATUS: drdata = status_word;
        default:    drdata = '0;
      endcase
    end else begin
      drdata = mem[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM lanes/aliasing, CYCLE, LED, unmapped space,
// TX FIFO fill/overrun/drain, push-with-pop on full and reset mid-stream.
module tb_dmem_mmio;

  logic        clk;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  we;
  logic [31:0] drdata;
  logic [31:0] led;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0000;
  localparam logic [31:0] A_LED    = 32'hFFFF_0004;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  dmem_mmio #(.MEM_WORDS(1024), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .we(we),
    .drdata(drdata), .led(led), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    daddr = a; dwdata = d; we = be;
    step();
    we = 4'b0000;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    daddr = a;
    #1;
    check(tag, drdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; daddr = '0; dwdata = '0; we = '0; tx_ready = 1'b0;
    step();
    step();
    check("rst_led", led, 32'h0);
    check("rst_valid", {31'd0, tx_valid}, 32'h0);
    rd("rst_status", A_STATUS, 32'h0000_0001);
    rd("rst_cycle0", A_CYCLE, 32'h0);
    reset = 1'b0;
    step();
    rd("cycle1", A_CYCLE, 32'd1);
    step();
    rd("cycle2", A_CYCLE, 32'd2);

    wr(A_CYCLE, 32'hFFFF_FFFE, 4'b1111);
    rd("cyc_wr", A_CYCLE, 32'hFFFF_FFFE);
    step();
    rd("cyc_max", A_CYCLE, 32'hFFFF_FFFF);
    step();
    rd("cyc_wrap", A_CYCLE, 32'h0);

    wr(32'h0000_0100, 32'h1122_3344, 4'b1111);
    wr(32'h0000_0100, 32'hAABB_CCDD, 4'b0101);
    rd("ram_lanes", 32'h0000_0100, 32'h11BB_33DD);
    rd("ram_alias", 32'h0000_1100, 32'h11BB_33DD);
    rd("ram_alias_hi", 32'h8000_0102, 32'h11BB_33DD);
    wr(32'h0000_0020, 32'hCAFE_F00D, 4'b1111);

    wr(A_LED, 32'hDEAD_BEEF, 4'b0011);
    check("led_lanes", led, 32'h0000_BEEF);
    rd("led_read", A_LED, 32'h0000_BEEF);
    wr(32'hFFFF_0020, 32'h1234_5678, 4'b1111);
    rd("unmapped_rd", 32'hFFFF_0020, 32'h0);
    check("unmapped_led", led, 32'h0000_BEEF);
    rd("mmio_no_ram", 32'h0000_0020, 32'hCAFE_F00D);
    rd("txdata_rd", A_TXDATA, 32'h0);

    for (int i = 0; i < 9; i++) begin
      wr(A_TXDATA, 32'(8'h41 + i), 4'b0001);
      if (i == 7) rd("status_full", A_STATUS, 32'h0000_0082);
    end
    rd("status_ovr", A_STATUS, 32'h0000_0086);
    check("head_41", {24'd0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", {31'd0, tx_valid}, 32'h1);
      check("drain_data", {24'd0, tx_data}, 32'(8'h41 + i));
      step();
    end
    check("drained_valid", {31'd0, tx_valid}, 32'h0);
    rd("status_empty_ovr", A_STATUS, 32'h0000_0005);
    wr(A_STATUS, 32'h0000_0004, 4'b0001);
    rd("status_clr", A_STATUS, 32'h0000_0001);

    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'(8'h61 + i), 4'b0001);
    rd("pp_full", A_STATUS, 32'h0000_0082);
    check("pp_head", {24'd0, tx_data}, 32'h61);
    tx_ready = 1'b1;
    wr(A_TXDATA, 32'h0000_005A, 4'b0001);
    rd("pp_status", A_STATUS, 32'h0000_0082);
    for (int i = 0; i < 8; i++) begin
      check("pp_data", {24'd0, tx_data}, (i == 7) ? 32'h5A : 32'(8'h62 + i));
      step();
    end
    check("pp_empty", {31'd0, tx_valid}, 32'h0);

    tx_ready = 1'b0;
    wr(A_TXDATA, 32'h0000_0071, 4'b0001);
    check("mid_valid", {31'd0, tx_valid}, 32'h1);
    reset = 1'b1;
    wr(A_TXDATA, 32'h0000_0072, 4'b0001);
    reset = 1'b0;
    check("mid_rst_valid", {31'd0, tx_valid}, 32'h0);
    check("mid_rst_led", led, 32'h0);
    rd("mid_rst_status", A_STATUS, 32'h0000_0001);
    rd("mid_rst_cycle", A_CYCLE, 32'h0);
    step();
    check("mid_discard", {31'd0, tx_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side responder for the single-cycle CPU: it sits on the CPU data port (`daddr`/`dwdata`/`we`/`drdata`) in place of plain data memory. It provides byte-lane-writable RAM plus a small memory-mapped peripheral region: a free-running cycle counter, an LED register, and a buffered byte-stream transmitter (TX FIFO) with a valid/ready output. Reads are combinational so the CPU completes loads in the same cycle.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of 2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of 2, at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `daddr`  in  32  byte address from the CPU; bits [1:0] are ignored (word access).
- `dwdata`  in  32  write data.
- `we`  in  4  byte-lane write enables; `we[i]` writes `dwdata[8i+7:8i]`.
- `drdata`  out  32  read data, combinational from `daddr`.
- `led`  out  32  LED register contents.
- `tx_valid`  out  1  FIFO not empty.
- `tx_data`  out  8  FIFO head byte.
- `tx_ready`  in  1  sink accepts `tx_data` when high together with `tx_valid`.

## Operation
- **Decode**
  - `daddr[31:16]==16'hFFFF` selects MMIO, with the register chosen by `daddr[5:2]`.
  - Any other address selects RAM at word index `daddr[log2(MEM_WORDS)+1:2]`. Upper bits are ignored, so RAM aliases/wraps.
- **RAM**
  - Each `we[i]` set writes byte lane i at the clock edge.
  - `we==0` means a read-only cycle.
  - RAM is not cleared by reset.
- **MMIO registers** (offset = `daddr[5:2]`)
  - 0 `CYCLE`
    - Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
    - A write merges the enabled byte lanes from `dwdata` and has priority over the increment that cycle.
  - 1 `LED`
    - Byte-lane R/W; drives `led`.
  - 2 `TXDATA`
    - A write with `we[0]=1` pushes `dwdata[7:0]`.
    - Reads return 0.
  - 3 `STATUS`, read-only bits:
    - bit0 = empty
    - bit1 = full
    - bit2 = overrun (sticky)
    - bits[7:4] = occupancy (saturating at 15 if `FIFO_DEPTH`>15)
    - all other bits 0
  - 3 `STATUS`, write: `we[0]=1` with `dwdata[2]=1` clears overrun.
  - Offsets 4–15: reads return 0; writes are ignored.
  - MMIO writes never touch RAM.
- **TX FIFO**
  - Circular buffer with separate read/write pointers and an occupancy count.
  - A pop occurs at an edge where `tx_valid && tx_ready`.
  - A push is accepted if the FIFO is not full, or if a pop occurs the same edge.
  - A push arriving when full with no pop is dropped. Overrun sets at that edge; contents and count are unchanged.
  - Simultaneous push and pop: the count is unchanged and both pointers advance.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `tx_data` is undefined-but-stable when empty; sinks qualify it with `tx_valid`.
- **Reset** (synchronous, overrides any write/push/pop that cycle):
  - `CYCLE`=0, `LED`=0, overrun=0.
  - FIFO pointers/count = 0.
  - Outputs after reset: `led`=0, `tx_valid`=0, `drdata` for `STATUS`=0x00000001, `drdata` for `CYCLE`=0.

## Timing
- `drdata` follows `daddr` combinationally; there is no read latency.
- Written RAM/register data is visible on `drdata` from the cycle after the write edge.
- `CYCLE`
  - Reads N in the cycle after the reset edge releases, counting from 0.
  - After a write of value V, it reads V in the next cycle and V+1 the cycle after.
- FIFO
  - `tx_valid` rises the cycle after the first push edge.
  - It falls the cycle after the edge that pops the last entry.
  - Maximum throughput is one push and one pop per cycle.
- `STATUS` reflects post-edge state, with the same one-cycle visibility as other registers.

## Test plan
- **RAM byte lanes**
  - Write 0x11223344 to 0x100 with `we`=4'b1111, then 0xAABBCCDD with `we`=4'b0101.
  - Required: read of 0x100 = 0x11BB33DD; read of 0x100+4·`MEM_WORDS` = same (alias).
- **Reset and CYCLE**
  - Hold reset 2 cycles, then release and sample `CYCLE` each cycle. Required: 0, 1, 2, …
  - Write 0xFFFFFFFE. Required: reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- **LED / unmapped**
  - Write 0xDEADBEEF to 0xFFFF0004 with `we`=4'b0011. Required: `led`=0x0000BEEF next cycle.
  - Write to 0xFFFF0020. Required: no effect; read returns 0.
- **FIFO fill and overrun**
  - With `tx_ready`=0, push 0x41..0x49 (9 bytes, `FIFO_DEPTH`=8).
  - Required: `STATUS`=0x86 (count 8, full, overrun).
  - Then raise `tx_ready`. Required: bytes 0x41..0x48 in order on consecutive cycles; then `tx_valid`=0 and `STATUS`=0x05.
  - Clear overrun. Required: `STATUS`=0x01.
- **Push/pop on full**
  - With the FIFO full and `tx_ready`=1, push 0x5A in the same cycle as a pop.
  - Required: count stays 8, overrun stays 0, 0x5A emerges 8th.
- **Reset mid-stream**
  - Assert reset in a cycle with a pending push and `tx_valid`=1.
  - Required: next cycle `tx_valid`=0, `STATUS`=0x01, `led`=0, pushed byte discarded.
